// File: rtl/demux_stream_router.sv
// demux_stream_router: registered, flow-controlled 1-to-M demultiplexer.
// Each output channel owns a one-entry holding register. Unicast words go to
// the channel chosen by in_sel, and broadcast words load every channel at once.
// Words addressed beyond the last channel are accepted, discarded and counted.
module demux_stream_router #(
    parameter int N  = 8,
    parameter int M  = 4,
    parameter int SW = $clog2(M)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_data,
    input  logic [SW-1:0]       in_sel,
    input  logic                in_bcast,
    output logic [M-1:0]        out_valid,
    input  logic [M-1:0]        out_ready,
    output logic [M-1:0][N-1:0] out_data,
    output logic [7:0]          drop_cnt
);

    // Holding registers and the discard counter.
    logic [M-1:0]        r_valid;
    logic [M-1:0][N-1:0] r_data;
    logic [7:0]          r_drop_cnt;

    // Decode and handshake wires.
    logic [M-1:0] w_free;      // channel empty or draining this cycle
    logic [M-1:0] w_hit;       // one-hot decode of in_sel
    logic         w_sel_ok;    // in_sel names an existing channel
    logic         w_sel_free;  // the addressed channel can take a word
    logic         w_accept;    // input transfer this cycle
    logic [M-1:0] w_load;      // per-channel load strobe
    logic         w_drop;      // accepted word is discarded

    // Select decode, ready generation and per-channel load strobes.
    // in_ready only depends on in_sel, in_bcast and channel state, never on in_valid/in_data.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
        w_free     = ~r_valid | out_ready;
        w_hit      = '0;
        w_sel_ok   = 1'b0;
        w_sel_free = 1'b0;
        in_ready   = 1'b1;
        w_accept   = 1'b0;
        w_load     = '0;
        w_drop     = 1'b0;

        for (int k = 0; k < M; k++) begin
            w_hit[k] = (in_sel == SW'(k));
        end
        w_sel_ok   = |w_hit;
        w_sel_free = |(w_hit & w_free);

        // Broadcast needs every channel free (no partial broadcast); an
        // out-of-range select is always ready because the word is just dropped.
        if (in_bcast) begin
            in_ready = &w_free;
        end else if (w_sel_ok) begin
            in_ready = w_sel_free;
        end else begin
            in_ready = 1'b1;
        end

        w_accept = in_valid & in_ready;
        if (w_accept) begin
            w_load = in_bcast ? {M{1'b1}} : w_hit;
        end
        w_drop = w_accept & ~in_bcast & ~w_sel_ok;
    end

    // Channel holding registers: load wins over drain, so a simultaneous
    // drain and load keeps valid high with the new word and no bubble.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_valid <= '0;
            // NOTE: the data registers are reset too because consumers are promised zero data after reset.
            r_data  <= '0;
        end else begin
            for (int k = 0; k < M; k++) begin
                if (w_load[k]) begin
                    r_data[k]  <= in_data;
                    r_valid[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Saturating count of words discarded for an out-of-range select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_demux_stream_router.sv
// Bench for demux_stream_router: a table of per-cycle vectors with hand-derived
// in_ready/out_valid expectations, plus a scoreboard of expected channel words,
// and hand-written sequences for out-of-range drops (M=3) and mid-run reset.
module tb_demux_stream_router;

    localparam int N = 8;
    localparam int M = 4;

    typedef struct {
        logic         valid;
        logic         bcast;
        logic [1:0]   sel;
        logic [7:0]   data;
        logic [3:0]   ready;
        logic         exp_rdy;  // expected in_ready this cycle
        logic [3:0]   exp_ov;   // expected out_valid this cycle (pre-edge)
    } vec_t;

    typedef struct {
        int         ch;
        logic [7:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Main DUT, M=4
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [N-1:0]        in_data  = '0;
    logic [1:0]          in_sel   = '0;
    logic                in_bcast = 1'b0;
    logic [M-1:0]        out_valid;
    logic [M-1:0]        out_ready = '0;
    logic [M-1:0][N-1:0] out_data;
    logic [7:0]          drop_cnt;

    // Second DUT, M=3, for out-of-range selects
    logic          m3_in_valid = 1'b0;
    logic          m3_in_ready;
    logic [N-1:0]  m3_in_data  = '0;
    logic [1:0]    m3_in_sel   = '0;
    logic          m3_in_bcast = 1'b0;
    logic [2:0]    m3_out_valid;
    logic [2:0]    m3_out_ready = '0;
    logic [2:0][N-1:0] m3_out_data;
    logic [7:0]    m3_drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    sb_t  sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    demux_stream_router #(.N(N), .M(M)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt)
    );

    demux_stream_router #(.N(N), .M(3)) dut_m3 (
        .clk(clk), .rst(rst),
        .in_valid(m3_in_valid), .in_ready(m3_in_ready), .in_data(m3_in_data),
        .in_sel(m3_in_sel), .in_bcast(m3_in_bcast),
        .out_valid(m3_out_valid), .out_ready(m3_out_ready), .out_data(m3_out_data),
        .drop_cnt(m3_drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic valid, input logic bcast, input logic [1:0] sel,
                                input logic [7:0] data, input logic [3:0] ready,
                                input logic exp_rdy, input logic [3:0] exp_ov);
        vec_t v;
        v.valid = valid; v.bcast = bcast; v.sel = sel; v.data = data;
        v.ready = ready; v.exp_rdy = exp_rdy; v.exp_ov = exp_ov;
        return v;
    endfunction

    // Drive one vector at the falling edge, check handshake/valid/data, then
    // update the scoreboard with what the coming rising edge will do.
    task automatic apply(input vec_t v, input string tag);
        int idx;
        @(negedge clk);
        in_valid  = v.valid;
        in_bcast  = v.bcast;
        in_sel    = v.sel;
        in_data   = v.data;
        out_ready = v.ready;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
        check({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_ov));
        for (int k = 0; k < M; k++) begin
            idx = -1;
            for (int j = 0; j < sb.size(); j++) begin
                if (idx < 0 && sb[j].ch == k) idx = j;
            end
            if (idx >= 0) begin
                check($sformatf("%s out_data[%0d]", tag, k), 32'(out_data[k]), 32'(sb[idx].data));
                if (v.ready[k]) sb.delete(idx);
            end
        end
        if (v.valid && v.exp_rdy) begin
            for (int k = 0; k < M; k++) begin
                if (v.bcast || (int'(v.sel) == k)) begin
                    sb.push_back('{ch: k, data: v.data});
                end
            end
        end
    endtask

    initial begin
        // Reset for two edges, then check reset values on both instances.
        repeat (2) @(negedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset out_data", 32'(out_data), 32'h0);
        check("reset drop_cnt", 32'(drop_cnt), 32'h0);
        check("reset m3 drop_cnt", 32'(m3_drop_cnt), 32'h0);
        rst = 1'b0;

        // 1: single unicast to channel 2
        tbl.push_back(mk(1, 0, 2, 8'hA5, 4'hF, 1, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0100));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000));
        // 2: channel 1 stalled, second word waits, then drain+load same cycle
        tbl.push_back(mk(1, 0, 1, 8'h11, 4'b1101, 1, 4'b0000));
        tbl.push_back(mk(1, 0, 1, 8'h22, 4'b1101, 0, 4'b0010));
        tbl.push_back(mk(1, 0, 1, 8'h22, 4'b1101, 0, 4'b0010));
        tbl.push_back(mk(1, 0, 1, 8'h22, 4'b1111, 1, 4'b0010));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 1, 4'b0010));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000));
        // 3: broadcast blocked by full, stalled channel 3, then released
        tbl.push_back(mk(1, 0, 3, 8'h99, 4'b0111, 1, 4'b0000));
        tbl.push_back(mk(1, 1, 0, 8'h3C, 4'b0111, 0, 4'b1000));
        tbl.push_back(mk(1, 1, 2, 8'h3C, 4'b0111, 0, 4'b1000));
        tbl.push_back(mk(1, 1, 0, 8'h3C, 4'b1111, 1, 4'b1000));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 1, 4'b1111));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000));
        // 4: back-to-back stream 0x00..0x0F alternating channel 0 / 3
        for (int i = 0; i < 16; i++) begin
            tbl.push_back(mk(1, 0, (i % 2 == 0) ? 2'd0 : 2'd3, 8'(i), 4'hF, 1,
                             (i == 0) ? 4'b0000 : ((i % 2 == 1) ? 4'b0001 : 4'b1000)));
        end
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b1000));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000));
        // 6 (first half): fill channels 0..2 with readies low
        tbl.push_back(mk(1, 0, 0, 8'h01, 4'h0, 1, 4'b0000));
        tbl.push_back(mk(1, 0, 1, 8'h02, 4'h0, 1, 4'b0001));
        tbl.push_back(mk(1, 0, 2, 8'h03, 4'h0, 1, 4'b0011));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'h0, 0, 4'b0111));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end
        check("stream no drops", 32'(drop_cnt), 32'h0);
        check("scoreboard holds 3 words", 32'(sb.size()), 32'd3);

        // 6: one-cycle reset while full, with a competing load offered
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        in_bcast  = 1'b0;
        in_data   = 8'hEE;
        out_ready = '0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post-reset out_valid", 32'(out_valid), 32'h0);
        check("post-reset out_data", 32'(out_data), 32'h0);
        check("post-reset drop_cnt", 32'(drop_cnt), 32'h0);
        sb.delete();
        apply(mk(1, 0, 0, 8'h77, 4'hF, 1, 4'b0000), "after-rst send");
        apply(mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0001), "after-rst out");
        apply(mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000), "after-rst idle");
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        // 5: M=3, 300 words to nonexistent channel 3; count saturates at 255
        begin
            int exp_drop = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                m3_in_valid  = 1'b1;
                m3_in_sel    = 2'd3;
                m3_in_bcast  = 1'b0;
                m3_in_data   = 8'(i);
                m3_out_ready = 3'b111;
                #1;
                check("m3 in_ready", 32'(m3_in_ready), 32'd1);
                check("m3 out_valid", 32'(m3_out_valid), 32'd0);
                check("m3 drop_cnt", 32'(m3_drop_cnt), 32'(exp_drop));
                if (exp_drop < 255) exp_drop++;
            end
            @(negedge clk);
            m3_in_valid = 1'b0;
            #1;
            check("m3 drop_cnt saturated", 32'(m3_drop_cnt), 32'd255);
            // A legal select on the M=3 instance still routes normally.
            m3_in_valid = 1'b1;
            m3_in_sel   = 2'd2;
            m3_in_data  = 8'h5A;
            @(negedge clk);
            m3_in_valid = 1'b0;
            #1;
            check("m3 sel2 out_valid", 32'(m3_out_valid), 32'b100);
            check("m3 sel2 out_data", 32'(m3_out_data[2]), 32'h5A);
            check("m3 drop_cnt held", 32'(m3_drop_cnt), 32'd255);
            // Reset clears the saturated counter.
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("m3 reset drop_cnt", 32'(m3_drop_cnt), 32'd0);
            check("m3 reset out_valid", 32'(m3_out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
